mfm_byte_decoder: RTL
=====================

Name: mfm_byte_decoder

Overview:
- Sits directly upstream of the sector header parser.
- Takes the recovered MFM cell stream from the data separator/PLL: one cell per strobe, clock and data cells interleaved.
- Detects the A1 missing-clock sync word, aligns byte framing to it, and emits decoded data bytes.
- Its o_Sync, o_Data and o_Valid outputs drive the parser's i_Sync, i_Data and i_Valid inputs directly.

Parameters:
SYNC_WORD, 16'h4489, raw MFM cell pattern of the A1 sync mark (clock, data pairs, MSB first)
SYNC_BYTE, 8'hA1, decoded byte emitted for each sync mark
LOSS_COUNT, 4, consecutive code-violating bytes that drop lock (1..15)

Ports:
i_Clk  input  1  system clock
i_Reset  input  1  asynchronous, active-high reset
i_Cell  input  1  current MFM cell value (1 = flux transition)
i_CellValid  input  1  one-cycle strobe, i_Cell valid; minimum 3 clocks between strobes
o_Data  output  8  decoded byte, MSB first
o_Valid  output  1  one-cycle pulse, o_Data valid
o_Sync  output  1  one-cycle pulse, sync word detected
o_Locked  output  1  byte framing established
o_CodeError  output  1  one-cycle pulse with o_Valid when the byte's cell window violates MFM
o_Errors  output  4  consecutive violating byte count, saturating

Behaviour:
- Reset is asynchronous on i_Reset, clock is i_Clk.
- Reset values: shift register 0, cell counter 0, all outputs 0, o_Locked 0. Reset mid-byte discards the partial byte; no pulse follows release.
- Cell shift register:
  - On i_CellValid: sr <= {sr[14:0], i_Cell}. No strobe: sr holds.
  - Decoded byte = {sr[14], sr[12], sr[10], sr[8], sr[6], sr[4], sr[2], sr[0]} (data cells). Odd bits are clock cells.
- Sync detection, evaluated on the post-shift value, highest priority:
  - Cycle N+1 after the strobe edge N: o_Sync = 1.
  - Cycle N+2: o_Valid = 1, o_Data = SYNC_BYTE.
  - Sync and valid are never in the same cycle; the downstream parser gives sync priority and would drop the byte otherwise.
  - Cell counter cleared to 0, o_Locked set to 1, o_Errors cleared.
  - Sync detection is active both locked and unlocked; a sync while locked re-aligns framing.
- Normal byte: locked, no sync, counter == 15 on a strobe.
  - Counter wraps to 0.
  - Next cycle: o_Valid = 1, o_Data = decoded byte.
  - Otherwise, each strobe increments the counter.
  - Unlocked: no o_Valid except sync bytes.
- Code check, normal bytes only: violation if (sr & (sr >> 1)) != 0, i.e. two adjacent 1 cells in the post-shift 16-cell window.
  - Violation: o_CodeError pulses with o_Valid, o_Errors increments (saturates at 15).
  - Clean byte: o_Errors cleared.
  - When o_Errors reaches LOSS_COUNT: o_Locked cleared the same cycle as that byte's o_Valid; o_Errors held until next sync.
  - The violating byte is still emitted.
- Sync bytes never flag o_CodeError. The missing clock is intentional.
- States: UNLOCKED → (sync) → LOCKED; LOCKED → (sync) → LOCKED (realign); LOCKED → (LOSS_COUNT errors) → UNLOCKED.
- Latency: 1 clock from completing strobe to o_Valid for data bytes; 2 clocks for sync bytes.
- Three back-to-back A1 marks produce three o_Sync pulses, each followed by an A1 byte, 16 cells apart. The framing counter never drifts across them.

Decomposition:
- Shared package floppy_pkg:
  - MFM_SYNC_A1 = 16'h4489, SYNC_BYTE_A1 = 8'hA1
  - IDAM mark 8'hFE, DAM mark 8'hFB
  - Cell/byte widths
  - The sector header parser also imports these.
- One natural sub-module: mfm_cell_shifter.
  - Contents: 16-bit shift register, sync compare, data-cell extraction, adjacency check.
  - Purely registered shift plus combinational outputs.
- Framing counter, lock FSM, error counter and output registers live in the top.

Test Plan:
- Reset, then 64 random cells with no 4489 → o_Valid, o_Sync and o_Locked stay 0.
- Cells 4E gap (0x9254 pattern) ×4, then 4489 ×3, then MFM of FE 01 00 03 02 → three o_Sync, each followed 1 cycle later by o_Data = A1, then bytes FE, 01, 00, 03, 02. o_Locked = 1, no o_CodeError.
- Feed that decoder output into the sector header parser with the correct CRC → parser o_Valid = 1, track 1, side 0, sector 3, size 2.
- Locked; insert 4 consecutive byte windows containing "11" cells → four o_CodeError pulses with o_Errors 1, 2, 3, 4; o_Locked drops with the 4th o_Valid; further cells produce no o_Valid until the next 4489.
- Locked mid-byte (counter = 7); inject 4489 → o_Sync, realigned A1; the next 16 cells decode as one byte.
- Assert i_Reset at counter = 9 while locked → all outputs 0 immediately; after release, no o_Valid until a new 4489.

Source files
------------

// File: rtl/floppy_pkg.sv
// floppy_pkg
// Shared constants and helpers for the floppy read path. The MFM byte
// decoder and the sector header parser both import this package, so the
// sync word, address marks and field widths are defined once here.
//
// Contents:
//   CELL_WIDTH / BYTE_WIDTH / ERR_WIDTH - cell window, byte and error count widths
//   MFM_SYNC_A1, SYNC_BYTE_A1           - raw A1 missing-clock mark and its decoded byte
//   IDAM_MARK, DAM_MARK                 - address marks that follow the A1 syncs
//   lock_state_e                        - byte framing lock states
//   mfm_data_cells()                    - pick the data cells out of a 16-cell window
//   mfm_has_violation()                 - adjacent-1 check over a 16-cell window
package floppy_pkg;

  localparam int CELL_WIDTH = 16;
  localparam int BYTE_WIDTH = 8;
  localparam int ERR_WIDTH  = 4;

  localparam logic [CELL_WIDTH-1:0] MFM_SYNC_A1  = 16'h4489;
  localparam logic [BYTE_WIDTH-1:0] SYNC_BYTE_A1 = 8'hA1;
  localparam logic [BYTE_WIDTH-1:0] IDAM_MARK    = 8'hFE;
  localparam logic [BYTE_WIDTH-1:0] DAM_MARK     = 8'hFB;

  typedef enum logic {
    LOCK_UNLOCKED = 1'b0,
    LOCK_LOCKED   = 1'b1
  } lock_state_e;

  // Cells arrive as (clock, data) pairs, MSB first, so the data cells sit on
  // the even bit positions of the window.
  function automatic logic [BYTE_WIDTH-1:0] mfm_data_cells(input logic [CELL_WIDTH-1:0] cells);
    logic [BYTE_WIDTH-1:0] result;
    result = '0;
    for (int i = 0; i < BYTE_WIDTH; i++) begin
      result[i] = cells[2*i];
    end
    return result;
  endfunction

  // Legal MFM never places two flux transitions in adjacent cells.
  function automatic logic mfm_has_violation(input logic [CELL_WIDTH-1:0] cells);
    return |(cells & (cells >> 1));
  endfunction

endpackage

// File: rtl/mfm_cell_shifter.sv
// mfm_cell_shifter
// Holds the last 16 recovered MFM cells and exposes combinational views of
// that window: sync word compare, decoded data byte and the MFM adjacency
// check. The register only moves on a cell strobe, so every output reflects
// the post-shift window from the clock after the strobe onward.
//
// Ports:
//   i_Clk        - system clock
//   i_Reset      - asynchronous, active-high reset (clears the window)
//   i_Cell       - current cell value, 1 = flux transition
//   i_CellValid  - one-cycle strobe qualifying i_Cell
//   o_SyncHit    - window equals SYNC_WORD
//   o_DataByte   - data cells of the window, MSB first
//   o_Violation  - window contains two adjacent 1 cells
module mfm_cell_shifter
  import floppy_pkg::*;
#(
  parameter logic [CELL_WIDTH-1:0] SYNC_WORD = MFM_SYNC_A1
) (
  input  logic                  i_Clk,
  input  logic                  i_Reset,
  input  logic                  i_Cell,
  input  logic                  i_CellValid,
  output logic                  o_SyncHit,
  output logic [BYTE_WIDTH-1:0] o_DataByte,
  output logic                  o_Violation
);

  logic [CELL_WIDTH-1:0] r_Cells;

  // Shift the new cell in at the LSB on each strobe; hold otherwise.
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      r_Cells <= '0;
    end else if (i_CellValid) begin
      r_Cells <= {r_Cells[CELL_WIDTH-2:0], i_Cell};
    end
  end

  assign o_SyncHit   = (r_Cells == SYNC_WORD);
  assign o_DataByte  = mfm_data_cells(r_Cells);
  assign o_Violation = mfm_has_violation(r_Cells);

endmodule

// File: rtl/mfm_byte_decoder.sv
// mfm_byte_decoder
// Turns the recovered MFM cell stream into decoded bytes for the sector
// header parser. It hunts for the A1 missing-clock sync word, aligns byte
// framing to it, and then emits one byte every 16 cells while locked. Bytes
// whose cell window breaks the MFM adjacency rule are still emitted but
// flagged, and a run of LOSS_COUNT such bytes drops lock until the next sync.
//
// Ports:
//   i_Clk        - system clock
//   i_Reset      - asynchronous, active-high reset
//   i_Cell       - current MFM cell value (1 = flux transition)
//   i_CellValid  - one-cycle strobe, at least 3 clocks apart
//   o_Data       - decoded byte, MSB first
//   o_Valid      - one-cycle pulse, o_Data valid
//   o_Sync       - one-cycle pulse, sync word detected
//   o_Locked     - byte framing established
//   o_CodeError  - pulses with o_Valid when the byte's cell window violates MFM
//   o_Errors     - consecutive violating byte count, saturating
module mfm_byte_decoder
  import floppy_pkg::*;
#(
  parameter logic [CELL_WIDTH-1:0] SYNC_WORD  = MFM_SYNC_A1,
  parameter logic [BYTE_WIDTH-1:0] SYNC_BYTE  = SYNC_BYTE_A1,
  parameter int unsigned           LOSS_COUNT = 4
) (
  input  logic                  i_Clk,
  input  logic                  i_Reset,
  input  logic                  i_Cell,
  input  logic                  i_CellValid,
  output logic [BYTE_WIDTH-1:0] o_Data,
  output logic                  o_Valid,
  output logic                  o_Sync,
  output logic                  o_Locked,
  output logic                  o_CodeError,
  output logic [ERR_WIDTH-1:0]  o_Errors
);

  localparam logic [ERR_WIDTH-1:0] LOSS_LIMIT = ERR_WIDTH'(LOSS_COUNT);
  localparam logic [ERR_WIDTH-1:0] ERR_MAX    = '1;
  localparam logic [3:0]           LAST_CELL  = 4'd15;

  logic                  w_SyncHit;
  logic [BYTE_WIDTH-1:0] w_DataByte;
  logic                  w_Violation;
  logic [ERR_WIDTH-1:0]  w_ErrorsInc;

  lock_state_e           r_State;
  logic                  r_StrobeD;
  logic                  r_SyncPend;
  logic [3:0]            r_Count;
  logic [BYTE_WIDTH-1:0] r_Data;
  logic                  r_Valid;
  logic                  r_Sync;
  logic                  r_CodeError;
  logic [ERR_WIDTH-1:0]  r_Errors;

  mfm_cell_shifter #(
    .SYNC_WORD (SYNC_WORD)
  ) u_shifter (
    .i_Clk       (i_Clk),
    .i_Reset     (i_Reset),
    .i_Cell      (i_Cell),
    .i_CellValid (i_CellValid),
    .o_SyncHit   (w_SyncHit),
    .o_DataByte  (w_DataByte),
    .o_Violation (w_Violation)
  );

  assign w_ErrorsInc = (r_Errors == ERR_MAX) ? r_Errors : r_Errors + 1'b1;

  // Framing, lock FSM and output registers.
  // Everything is evaluated one clock after a strobe (r_StrobeD), when the
  // shifter window already holds the post-shift cells. A sync hit wins over
  // a byte boundary: it pulses o_Sync now and parks the A1 byte in
  // r_SyncPend so o_Valid follows a clock later, never together with o_Sync.
  // The strobe spacing guarantees the parked A1 cannot collide with the next
  // strobe's evaluation.
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      r_State     <= LOCK_UNLOCKED;
      r_StrobeD   <= 1'b0;
      r_SyncPend  <= 1'b0;
      r_Count     <= '0;
      r_Data      <= '0;
      r_Valid     <= 1'b0;
      r_Sync      <= 1'b0;
      r_CodeError <= 1'b0;
      r_Errors    <= '0;
    end else begin
      r_StrobeD   <= i_CellValid;
      r_SyncPend  <= 1'b0;
      r_Valid     <= 1'b0;
      r_Sync      <= 1'b0;
      r_CodeError <= 1'b0;

      if (r_SyncPend) begin
        r_Valid <= 1'b1;
        r_Data  <= SYNC_BYTE;
      end

      if (r_StrobeD) begin
        if (w_SyncHit) begin
          r_Sync     <= 1'b1;
          r_SyncPend <= 1'b1;
          r_Count    <= '0;
          r_State    <= LOCK_LOCKED;
          r_Errors   <= '0;
        end else begin
          r_Count <= r_Count + 1'b1;
          if ((r_State == LOCK_LOCKED) && (r_Count == LAST_CELL)) begin
            r_Valid <= 1'b1;
            r_Data  <= w_DataByte;
            if (w_Violation) begin
              r_CodeError <= 1'b1;
              r_Errors    <= w_ErrorsInc;
              if (w_ErrorsInc >= LOSS_LIMIT) begin
                r_State <= LOCK_UNLOCKED;
              end
            end else begin
              r_Errors <= '0;
            end
          end
        end
      end
    end
  end

  assign o_Data      = r_Data;
  assign o_Valid     = r_Valid;
  assign o_Sync      = r_Sync;
  assign o_Locked    = (r_State == LOCK_LOCKED);
  assign o_CodeError = r_CodeError;
  assign o_Errors    = r_Errors;

endmodule
